vc_rr_arbiter: RTL and testbench

- Round-robin arbiter between four input FIFOs (push/pop FIFO instances, DW-bit words) and four output FIFOs.
- Each cycle it pops at most one non-empty input FIFO.
- It captures the word after the FIFO read latency, decodes the destination from the word's top two bits, and pushes the word into the matching output FIFO.
- It applies backpressure from output almost_full flags and flags words lost to a full output.

---
 rtl/vc_rr_arbiter.sv | 104 ++++++++++
 tb/tb_vc_rr_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/vc_rr_arbiter.sv
// vc_rr_arbiter: round-robin mover from 4 input FIFOs to 4 output FIFOs routed by word[DW-1:DW-2]; ports: in_empty/in_data/in_pop, out_almost_full/out_full/out_push/out_data, state, idle, error
module vc_rr_arbiter #(
  parameter int DW = 10,
  parameter int RD_LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      in_empty,
  input  logic [4*DW-1:0] in_data,
  output logic [3:0]      in_pop,
  input  logic [3:0]      out_almost_full,
  input  logic [3:0]      out_full,
  output logic [3:0]      out_push,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      state,
  output logic            idle,
  output logic            error
);
  typedef enum logic [1:0] {S_RESET, S_IDLE, S_ACTIVE, S_STALL} state_t;
  state_t state_q, state_d;
  logic [3:0] pop_q, pop_d, push_q, push_d, mask, elig;
  logic [1:0] ptr_q, ptr_d, pop_idx_q, pop_idx_d, dst, cand;
  logic [RD_LATENCY-1:0] pv_q, pv_d;
  logic [1:0] pi_q [RD_LATENCY];
  logic [1:0] pi_d [RD_LATENCY];
  logic [DW-1:0] data_q, data_d, word;
  logic err_q, err_d, any_af, any_elig, pipe_empty, grant_en, found;
  always_comb begin
    mask = pop_q;
    for (int k = 0; k < RD_LATENCY - 1; k++) mask |= pv_q[k] ? (4'b0001 << pi_q[k]) : 4'b0000;
    elig = ~in_empty & ~mask;
    any_elig = |elig;
    any_af = |out_almost_full;
    pipe_empty = ~|pop_q && ~|pv_q;
    grant_en = (state_q == S_ACTIVE || state_q == S_IDLE) && !any_af && any_elig;
    pop_d = '0;
    pop_idx_d = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    cand = '0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (grant_en && !found && elig[cand]) begin
        found = 1'b1;
        pop_d[cand] = 1'b1;
        pop_idx_d = cand;
        ptr_d = cand + 2'd1;
      end
    end
    pv_d[0] = |pop_q;
    pi_d[0] = pop_idx_q;
    for (int k = 1; k < RD_LATENCY; k++) begin
      pv_d[k] = pv_q[k-1];
      pi_d[k] = pi_q[k-1];
    end
    word = in_data[int'(pi_q[RD_LATENCY-1])*DW +: DW];
    dst = word[DW-1:DW-2];
    push_d = '0;
    data_d = data_q;
    err_d = err_q;
    if (pv_q[RD_LATENCY-1]) begin
      if (out_full[dst]) err_d = 1'b1;
      else begin
        push_d[dst] = 1'b1;
        data_d = word;
      end
    end
    case (state_q)
      S_RESET:  state_d = S_IDLE;
      S_IDLE:   state_d = any_elig ? S_ACTIVE : S_IDLE;
      S_ACTIVE: state_d = any_af ? S_STALL : (!any_elig && pipe_empty) ? S_IDLE : S_ACTIVE;
      default:  state_d = (!any_af && any_elig) ? S_ACTIVE : S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      pop_q <= '0;
      pop_idx_q <= '0;
      ptr_q <= '0;
      pv_q <= '0;
      pi_q <= '{default: '0};
      push_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pop_q <= pop_d;
      pop_idx_q <= pop_idx_d;
      ptr_q <= ptr_d;
      pv_q <= pv_d;
      pi_q <= pi_d;
      push_q <= push_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  end
  assign in_pop = pop_q;
  assign out_push = push_q;
  assign out_data = data_q;
  assign state = state_q;
  assign idle = state_q == S_IDLE && pipe_empty;
  assign error = err_q;
endmodule

// File: tb/tb_vc_rr_arbiter.sv
// tb_vc_rr_arbiter: directed self-checking bench for vc_rr_arbiter with DW=10, RD_LATENCY=2
module tb_vc_rr_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] in_empty, in_pop, out_almost_full, out_full, out_push;
  logic [39:0] in_data;
  logic [9:0] out_data;
  logic [1:0] state;
  logic idle, error;
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_pop [10] = '{4'h4, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0};
  logic [3:0] exp_push [10] = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h2};
  vc_rr_arbiter #(.DW(10), .RD_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .in_empty(in_empty), .in_data(in_data), .in_pop(in_pop),
    .out_almost_full(out_almost_full), .out_full(out_full), .out_push(out_push),
    .out_data(out_data), .state(state), .idle(idle), .error(error)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    in_empty = 4'h0;
    in_data = {10'h314, 10'h20F, 10'h10A, 10'h005};
    out_almost_full = 4'h0;
    out_full = 4'h0;
    repeat (3) tick();
    chk("rst_pop", 32'(in_pop), 0);
    chk("rst_push", 32'(out_push), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_err", 32'(error), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_idle", 32'(idle), 0);
    reset = 1'b0;
    tick();
    chk("e1_state", 32'(state), 1);
    chk("e1_idle", 32'(idle), 1);
    chk("e1_pop", 32'(in_pop), 0);
    tick();
    chk("rr_pop0", 32'(in_pop), 4'b0001);
    chk("rr_state", 32'(state), 2);
    tick();
    chk("rr_pop1", 32'(in_pop), 4'b0010);
    in_empty[0] = 1'b1;
    tick();
    chk("rr_pop2", 32'(in_pop), 4'b0100);
    in_empty[1] = 1'b1;
    tick();
    chk("rr_pop3", 32'(in_pop), 4'b1000);
    chk("rr_push0", 32'(out_push), 4'b0001);
    chk("rr_data0", 32'(out_data), 10'h005);
    in_empty[2] = 1'b1;
    tick();
    chk("rr_nopop", 32'(in_pop), 0);
    chk("rr_push1", 32'(out_push), 4'b0010);
    chk("rr_data1", 32'(out_data), 10'h10A);
    in_empty[3] = 1'b1;
    tick();
    chk("rr_push2", 32'(out_push), 4'b0100);
    chk("rr_data2", 32'(out_data), 10'h20F);
    tick();
    chk("rr_push3", 32'(out_push), 4'b1000);
    chk("rr_data3", 32'(out_data), 10'h314);
    tick();
    chk("rr_push_end", 32'(out_push), 0);
    chk("rr_hold", 32'(out_data), 10'h314);
    chk("rr_state_idle", 32'(state), 1);
    chk("rr_idle", 32'(idle), 1);
    in_data[20 +: 10] = 10'h1C3;
    in_empty = 4'b1011;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk($sformatf("mask_pop%0d", n), 32'(in_pop), 32'(exp_pop[n]));
      chk($sformatf("mask_push%0d", n), 32'(out_push), 32'(exp_push[n]));
      if (exp_push[n] != 4'h0) chk($sformatf("mask_data%0d", n), 32'(out_data), 10'h1C3);
      if (n == 7) in_empty = 4'hF;
    end
    tick();
    chk("mask_state", 32'(state), 1);
    chk("mask_idle", 32'(idle), 1);
    in_empty = 4'h0;
    tick();
    chk("bp_pop3", 32'(in_pop), 4'b1000);
    chk("bp_state_act", 32'(state), 2);
    tick();
    chk("bp_pop0", 32'(in_pop), 4'b0001);
    out_almost_full = 4'b0010;
    tick();
    chk("bp_stall_pop", 32'(in_pop), 0);
    chk("bp_stall_state", 32'(state), 3);
    tick();
    chk("bp_stall_pop2", 32'(in_pop), 0);
    chk("bp_inflight1", 32'(out_push), 4'b1000);
    chk("bp_inflight1_d", 32'(out_data), 10'h314);
    chk("bp_state_idle", 32'(state), 1);
    out_almost_full = 4'h0;
    tick();
    chk("bp_resume_pop", 32'(in_pop), 4'b0010);
    chk("bp_inflight2", 32'(out_push), 4'b0001);
    chk("bp_inflight2_d", 32'(out_data), 10'h005);
    chk("bp_resume_state", 32'(state), 2);
    in_empty = 4'hF;
    tick();
    chk("bp_gap1", 32'(out_push), 0);
    tick();
    chk("bp_gap2", 32'(out_push), 0);
    tick();
    chk("bp_push_res", 32'(out_push), 4'b0010);
    chk("bp_data_res", 32'(out_data), 10'h10A);
    in_data[30 +: 10] = 10'h3C1;
    in_empty = 4'b0111;
    out_full = 4'b1000;
    tick();
    chk("full_pop", 32'(in_pop), 4'b1000);
    tick();
    in_empty = 4'hF;
    tick();
    chk("full_err_pre", 32'(error), 0);
    tick();
    chk("full_push", 32'(out_push), 0);
    chk("full_err", 32'(error), 1);
    chk("full_hold", 32'(out_data), 10'h10A);
    tick();
    chk("full_err_sticky1", 32'(error), 1);
    out_full = 4'h0;
    tick();
    chk("full_err_sticky2", 32'(error), 1);
    chk("full_state", 32'(state), 1);
    in_empty = 4'b1110;
    tick();
    chk("rs_pop", 32'(in_pop), 4'b0001);
    tick();
    reset = 1'b1;
    tick();
    chk("rs_state", 32'(state), 0);
    chk("rs_push", 32'(out_push), 0);
    chk("rs_pop_clr", 32'(in_pop), 0);
    chk("rs_err", 32'(error), 0);
    chk("rs_data", 32'(out_data), 0);
    reset = 1'b0;
    in_empty = 4'h0;
    tick();
    chk("rs_state_idle", 32'(state), 1);
    chk("rs_push1", 32'(out_push), 0);
    tick();
    chk("rs_ptr0", 32'(in_pop), 4'b0001);
    chk("rs_push2", 32'(out_push), 0);
    tick();
    chk("rs_push3", 32'(out_push), 0);
    tick();
    chk("rs_push4", 32'(out_push), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
